pll_retune_seq: RTL and testbench

Sequencer that owns the PLL feedback-divider setting `divn`. It accepts retune requests through a valid/ready handshake and ramps `divn` toward the requested target in bounded steps, holding at each step so the frequency loops can follow. It then waits for confirmed lock and reports done or timeout. It sits between the system register interface and the PLL `divn` input, and freezes while the droop brake is active.

---
 rtl/pll_pkg.sv | 21 ++
 rtl/pll_retune_seq.sv | 153 +++++++++++++++
 tb/tb_pll_retune_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_pkg.sv
// Shared PLL types and default divider limits used by the PLL control blocks.
package pll_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STEP,
      S_HOLD,
      S_SETTLE,
      S_PAUSE
   } retune_state_t;

   typedef enum logic [1:0] {
      BRK_OFF,
      BRK_ENGAGED,
      BRK_RELEASE
   } brake_state_t;

   localparam int DIVN_MIN_DEF = 4;
   localparam int DIVN_MAX_DEF = 1023;

endpackage

// File: rtl/pll_retune_seq.sv
// Retune sequencer for the PLL feedback divider: accepts a target, ramps divn in
// bounded steps with a hold after each, then waits for confirmed lock or times out.
module pll_retune_seq
   import pll_pkg::*;
#(
   parameter int DIVN_RESET   = 10,
   parameter int DIVN_MIN     = DIVN_MIN_DEF,
   parameter int DIVN_MAX     = DIVN_MAX_DEF,
   parameter int STEP         = 1,
   parameter int HOLD_CYCLES  = 32,
   parameter int LOCK_CONFIRM = 16,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic               refclk,
   input  logic               resetn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic signed [31:0] req_divn,
   input  logic               brake,
   input  logic               lock,
   output logic signed [31:0] divn_out,
   output logic               busy,
   output logic               done,
   output logic               timeout_err
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
   localparam int LOCK_W = $clog2(LOCK_CONFIRM) + 1;
   localparam int TO_W   = $clog2(LOCK_TIMEOUT) + 1;

   retune_state_t      state_q, state_d;
   logic signed [31:0] divn_q, divn_d;
   logic signed [31:0] target_q, target_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [TO_W-1:0]    timeout_cnt_q, timeout_cnt_d;
   logic               done_q, done_d;
   logic               timeout_err_q, timeout_err_d;

   logic signed [32:0] diff;
   logic [32:0]        mag;
   logic signed [31:0] step_amt;

   function automatic logic signed [31:0] sat_divn(input logic signed [31:0] v);
      if (v < DIVN_MIN) return DIVN_MIN;
      if (v > DIVN_MAX) return DIVN_MAX;
      return v;
   endfunction

   // Distance is taken in 33 bits so the magnitude can never wrap.
   always_comb begin
      diff     = {target_q[31], target_q} - {divn_q[31], divn_q};
      mag      = diff[32] ? -diff : diff;
      step_amt = (mag > 33'(STEP)) ? 32'(STEP) : 32'(mag);
   end

   always_comb begin
      state_d       = state_q;
      divn_d        = divn_q;
      target_d      = target_q;
      hold_cnt_d    = hold_cnt_q;
      lock_cnt_d    = lock_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               target_d = sat_divn(req_divn);
               state_d  = S_STEP;
            end
         end
         S_STEP: begin
            if (brake) begin
               state_d = S_PAUSE;
            end else if (diff == '0) begin
               lock_cnt_d    = '0;
               timeout_cnt_d = '0;
               state_d       = S_SETTLE;
            end else begin
               divn_d     = diff[32] ? (divn_q - step_amt) : (divn_q + step_amt);
               hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (brake) begin
               state_d = S_PAUSE;
            end else if (hold_cnt_q == '0) begin
               state_d = S_STEP;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         S_SETTLE: begin
            if (brake) begin
               lock_cnt_d    = '0;
               timeout_cnt_d = '0;
               state_d       = S_PAUSE;
            end else begin
               timeout_cnt_d = timeout_cnt_q + TO_W'(1);
               lock_cnt_d    = lock ? (lock_cnt_q + LOCK_W'(1)) : '0;
               // Confirmed lock beats a coincident timeout.
               if (lock && (lock_cnt_q == LOCK_W'(LOCK_CONFIRM - 1))) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (timeout_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = S_IDLE;
               end
            end
         end
         S_PAUSE: begin
            lock_cnt_d    = '0;
            timeout_cnt_d = '0;
            if (!brake) begin
               hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
               state_d    = S_HOLD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         divn_q        <= DIVN_RESET;
         target_q      <= DIVN_RESET;
         hold_cnt_q    <= '0;
         lock_cnt_q    <= '0;
         timeout_cnt_q <= '0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         divn_q        <= divn_d;
         target_q      <= target_d;
         hold_cnt_q    <= hold_cnt_d;
         lock_cnt_q    <= lock_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE) && !brake;
   assign busy        = (state_q != S_IDLE);
   assign divn_out    = divn_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pll_retune_seq.sv
// Directed bench for pll_retune_seq: ramp timing, clamping, brake pause, timeout and reset abort.
module tb_pll_retune_seq;

   logic               refclk;
   logic               resetn;
   logic               req_valid, req_ready;
   logic signed [31:0] req_divn;
   logic               brake, lock;
   logic signed [31:0] divn_out;
   logic               busy, done, timeout_err;

   logic               r4_valid, r4_ready;
   logic signed [31:0] r4_divn;
   logic               brake4;
   logic signed [31:0] d4_divn;
   logic               d4_busy, d4_done, d4_terr;

   int n_run  = 0;
   int n_fail = 0;
   int min_seen = 10;
   int max_seen = 10;
   logic ok, seen;

   pll_retune_seq #(
      .DIVN_RESET(10), .DIVN_MIN(4), .DIVN_MAX(1023), .STEP(1),
      .HOLD_CYCLES(4), .LOCK_CONFIRM(16), .LOCK_TIMEOUT(64)
   ) u_dut (
      .refclk(refclk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_divn(req_divn), .brake(brake), .lock(lock), .divn_out(divn_out),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   pll_retune_seq #(
      .DIVN_RESET(10), .DIVN_MIN(4), .DIVN_MAX(1023), .STEP(4),
      .HOLD_CYCLES(4), .LOCK_CONFIRM(16), .LOCK_TIMEOUT(64)
   ) u_dut4 (
      .refclk(refclk), .resetn(resetn), .req_valid(r4_valid), .req_ready(r4_ready),
      .req_divn(r4_divn), .brake(brake4), .lock(lock), .divn_out(d4_divn),
      .busy(d4_busy), .done(d4_done), .timeout_err(d4_terr)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   always @(negedge refclk) begin
      if (divn_out < min_seen) min_seen <= divn_out;
      if (divn_out > max_seen) max_seen <= divn_out;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic wait_done(input bit use4, input int budget, output logic got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (use4 ? d4_done : done) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_divn = 0; brake = 1'b0; lock = 1'b0;
      r4_valid = 1'b0; r4_divn = 0; brake4 = 1'b0;
      tick(3);
      chk("rst_divn", divn_out, 10);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_terr", timeout_err, 0);
      resetn = 1'b1;
      tick(1);

      // brake in IDLE blocks acceptance only
      brake = 1'b1; req_valid = 1'b1; req_divn = 20;
      tick(1);
      chk("idle_brake_busy", busy, 0);
      chk("idle_brake_ready", req_ready, 0);
      chk("idle_brake_divn", divn_out, 10);
      brake = 1'b0; req_valid = 1'b0;
      tick(1);

      // ramp 10 -> 13, five cycles per step, done 16 cycles after SETTLE entry
      req_divn = 13; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      chk("acc_divn", divn_out, 10);
      chk("acc_busy", busy, 1);
      chk("acc_ready", req_ready, 0);
      tick(1); chk("ramp_11", divn_out, 11);
      tick(4); chk("ramp_11_hold", divn_out, 11);
      tick(1); chk("ramp_12", divn_out, 12);
      tick(4); chk("ramp_12_hold", divn_out, 12);
      tick(1); chk("ramp_13", divn_out, 13);
      tick(5); chk("settle_divn", divn_out, 13);
      chk("settle_busy", busy, 1);
      lock = 1'b1;
      tick(15); chk("done_early", done, 0);
      tick(1);  chk("done_pulse", done, 1);
      chk("done_idle", busy, 0);
      tick(1);  chk("done_single", done, 0);

      // zero-distance request, lock low: timeout 64 cycles after SETTLE entry
      lock = 1'b0; req_divn = 13; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(1);
      chk("zero_settle_busy", busy, 1);
      tick(63); chk("terr_early", timeout_err, 0);
      tick(1);  chk("terr_pulse", timeout_err, 1);
      chk("terr_no_done", done, 0);
      chk("terr_idle", busy, 0);
      chk("terr_divn", divn_out, 13);

      // lock toggling every 10 cycles never confirms
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(1);
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i % 10 == 0) lock = ~lock;
         tick(1);
         seen = seen | done;
      end
      chk("toggle_terr", timeout_err, 1);
      chk("toggle_no_done", seen, 0);

      // brake for 7 cycles during HOLD at 12
      lock = 1'b1; req_divn = 10; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(1); chk("brk_pre", divn_out, 12);
      brake = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         seen = seen | (divn_out != 12) | req_ready | !busy;
      end
      chk("brk_frozen", seen, 0);
      brake = 1'b0;
      tick(5); chk("brk_recover_hold", divn_out, 12);
      chk("brk_ready", req_ready, 0);
      tick(1); chk("brk_resume", divn_out, 11);
      wait_done(1'b0, 100, ok);
      chk("brk_done", ok, 1);
      chk("brk_final", divn_out, 10);

      // reset asserted mid-HOLD at 12
      req_divn = 13; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(6); chk("rst_mid_pre", divn_out, 12);
      tick(1);
      resetn = 1'b0;
      #1;
      chk("rst_mid_divn", divn_out, 10);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", req_ready, 1);
      tick(2);
      resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         seen = seen | done | timeout_err | busy;
      end
      chk("rst_mid_quiet", seen, 0);

      // clamping below DIVN_MIN and above DIVN_MAX
      req_divn = 3; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      wait_done(1'b0, 300, ok);
      chk("clamp_lo_done", ok, 1);
      chk("clamp_lo_divn", divn_out, 4);
      req_divn = 5000; req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      wait_done(1'b0, 6000, ok);
      chk("clamp_hi_done", ok, 1);
      chk("clamp_hi_divn", divn_out, 1023);

      // STEP=4 instance: 10 -> 14, 18, 21
      r4_divn = 21; r4_valid = 1'b1;
      tick(1);
      r4_valid = 1'b0;
      chk("s4_acc", d4_divn, 10);
      tick(1); chk("s4_14", d4_divn, 14);
      tick(5); chk("s4_18", d4_divn, 18);
      tick(5); chk("s4_21", d4_divn, 21);
      tick(5); chk("s4_no_overshoot", d4_divn, 21);
      wait_done(1'b1, 100, ok);
      chk("s4_done", ok, 1);
      r4_divn = -5; r4_valid = 1'b1;
      tick(1);
      r4_valid = 1'b0;
      wait_done(1'b1, 200, ok);
      chk("s4_neg_done", ok, 1);
      chk("s4_neg_clamp", d4_divn, 4);

      tick(1);
      chk("range_min", min_seen, 4);
      chk("range_max", max_seen, 1023);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
